// File: rtl/dma_engine.sv
// Word-block DMA between DRAM and the SRAM scratchpad, plus SRAM fill; stalls the pipeline while busy.
// Latency: command accepted combinationally in IDLE, dmaDone pulses one cycle after the last destination write.
// Backpressure: source side halts while the FIFO is full; DRAM requests hold until dramAck.

module dma_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_dat,
    output logic [W-1:0]     head_dat,
    output logic [PTR_W:0]   count
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_dat;
    end
endmodule

module dma_engine #(
    parameter int ADDR_W     = 32,
    parameter int WIDTH_W    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         dmaCmd,
    input  logic [ADDR_W-1:0]  dmaSrcAddress,
    input  logic [ADDR_W-1:0]  dmaDstAddress,
    input  logic [WIDTH_W-1:0] dmaWidth,
    output logic               stall,
    output logic               dmaDone,
    output logic               dramReq,
    output logic               dramWrite,
    output logic [ADDR_W-1:0]  dramAddress,
    output logic [31:0]        dramWriteData,
    input  logic               dramAck,
    input  logic [31:0]        dramReadData,
    output logic [ADDR_W-1:0]  sramAddress,
    output logic               sramWriteEnable,
    output logic [31:0]        sramWriteData,
    input  logic [31:0]        sramReadData
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {IDLE, XFER, FILL, DONE} state_t;

    state_t              state_q, state_d;
    logic                s2d_q, s2d_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [WIDTH_W-1:0]  width_q, width_d, fetched_q, fetched_d, written_q, written_d;
    logic                accept, can_fetch, fifo_nonempty;
    logic                push, pop, fifo_clr;
    logic [31:0]         push_dat, head_dat;
    logic [CNT_W-1:0]    fifo_cnt;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    assign accept        = (state_q == IDLE) && (dmaCmd != 2'b00) && (dmaWidth != '0);
    // Registered count only: a pop in the same cycle must not let a push through.
    assign can_fetch     = (state_q == XFER) && (fetched_q != width_q)
                           && (fifo_cnt < CNT_W'(FIFO_DEPTH));
    assign fifo_nonempty = (fifo_cnt != '0);

    always_comb begin
        state_d         = state_q;
        s2d_d           = s2d_q;
        src_d           = src_q;
        dst_d           = dst_q;
        width_d         = width_q;
        fetched_d       = fetched_q;
        written_d       = written_q;
        push            = 1'b0;
        pop             = 1'b0;
        fifo_clr        = 1'b0;
        push_dat        = dramReadData;
        stall           = 1'b0;
        dmaDone         = 1'b0;
        dramReq         = 1'b0;
        dramWrite       = 1'b0;
        dramAddress     = '0;
        dramWriteData   = '0;
        sramAddress     = '0;
        sramWriteEnable = 1'b0;
        sramWriteData   = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    s2d_d     = (dmaCmd == 2'b10);
                    src_d     = dmaSrcAddress;
                    dst_d     = dmaDstAddress;
                    width_d   = dmaWidth;
                    fetched_d = '0;
                    written_d = '0;
                    fifo_clr  = 1'b1;
                    state_d   = (dmaCmd == 2'b11) ? FILL : XFER;
                end
            end
            XFER: begin
                stall = 1'b1;
                if (!s2d_q) begin
                    dramReq         = can_fetch;
                    dramAddress     = word_addr(src_q);
                    push            = can_fetch && dramAck;
                    push_dat        = dramReadData;
                    sramWriteEnable = fifo_nonempty;
                    sramAddress     = word_addr(dst_q);
                    sramWriteData   = head_dat;
                    pop             = fifo_nonempty;
                end else begin
                    sramAddress     = word_addr(src_q);
                    push            = can_fetch;
                    push_dat        = sramReadData;
                    dramReq         = fifo_nonempty;
                    dramWrite       = fifo_nonempty;
                    dramAddress     = word_addr(dst_q);
                    dramWriteData   = head_dat;
                    pop             = fifo_nonempty && dramAck;
                end
                if (push) begin
                    src_d     = src_q + WORD_STEP;
                    fetched_d = fetched_q + WIDTH_W'(1);
                end
                if (pop) begin
                    dst_d     = dst_q + WORD_STEP;
                    written_d = written_q + WIDTH_W'(1);
                    if (written_q + WIDTH_W'(1) == width_q) state_d = DONE;
                end
            end
            FILL: begin
                stall           = 1'b1;
                sramWriteEnable = 1'b1;
                sramAddress     = word_addr(dst_q);
                sramWriteData   = 32'(src_q);
                dst_d           = dst_q + WORD_STEP;
                written_d       = written_q + WIDTH_W'(1);
                if (written_q + WIDTH_W'(1) == width_q) state_d = DONE;
            end
            DONE: begin
                // Held instruction still presents its command here; leaving via IDLE next cycle avoids a re-trigger.
                dmaDone = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s2d_q     <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            width_q   <= '0;
            fetched_q <= '0;
            written_q <= '0;
        end else begin
            state_q   <= state_d;
            s2d_q     <= s2d_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            width_q   <= width_d;
            fetched_q <= fetched_d;
            written_q <= written_d;
        end
    end

    dma_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clr      (fifo_clr),
        .push     (push),
        .pop      (pop),
        .push_dat (push_dat),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );
endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: a word-level reference model queues expected SRAM/DRAM
// traffic per command, and a negedge monitor pops and compares whatever the DUT presents.
module tb_dma_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dmaCmd;
    logic [31:0] dmaSrcAddress, dmaDstAddress;
    logic [9:0]  dmaWidth;
    logic        stall, dmaDone, dramReq, dramWrite, dramAck;
    logic [31:0] dramAddress, dramWriteData, dramReadData;
    logic [31:0] sramAddress, sramWriteData, sramReadData;
    logic        sramWriteEnable;

    always #5 clk = ~clk;

    dma_engine #(.ADDR_W(32), .WIDTH_W(10), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .dmaCmd          (dmaCmd),
        .dmaSrcAddress   (dmaSrcAddress),
        .dmaDstAddress   (dmaDstAddress),
        .dmaWidth        (dmaWidth),
        .stall           (stall),
        .dmaDone         (dmaDone),
        .dramReq         (dramReq),
        .dramWrite       (dramWrite),
        .dramAddress     (dramAddress),
        .dramWriteData   (dramWriteData),
        .dramAck         (dramAck),
        .dramReadData    (dramReadData),
        .sramAddress     (sramAddress),
        .sramWriteEnable (sramWriteEnable),
        .sramWriteData   (sramWriteData),
        .sramReadData    (sramReadData)
    );

    logic [31:0] sram_mem [256];
    logic [31:0] dram_mem [256];
    assign sramReadData = sram_mem[sramAddress[9:2]];

    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } dram_op_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } sram_op_t;

    dram_op_t exp_dram[$];
    sram_op_t exp_sram[$];
    int exp_done    = 0;
    int sram_wr_cnt = 0;
    int dram_lat    = 1;
    int n_pass      = 0;
    int n_total     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // DRAM: acks after dram_lat waiting cycles of a request, one-cycle ack.
    initial begin
        int cnt;
        cnt = 0;
        dramAck = 1'b0;
        dramReadData = '0;
        forever begin
            @(posedge clk); #1;
            if (dramAck) begin
                dramAck = 1'b0;
                cnt = 0;
            end
            if (dramReq) begin
                if (cnt >= dram_lat) begin
                    dramAck = 1'b1;
                    dramReadData = dram_mem[dramAddress[9:2]];
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_wait;
        logic        prev_wr;
        logic [31:0] prev_addr, prev_data;
        sram_op_t    s;
        dram_op_t    d;
        prev_wait = 1'b0;
        prev_wr = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (prev_wait) begin
                chk("dram_req_held", 32'(dramReq), 1);
                chk("dram_addr_stable", dramAddress, prev_addr);
                chk("dram_dir_stable", 32'(dramWrite), 32'(prev_wr));
                if (prev_wr) chk("dram_wdata_stable", dramWriteData, prev_data);
            end
            if (sramWriteEnable) begin
                chk("sram_write_expected", 32'(exp_sram.size() != 0), 1);
                if (exp_sram.size() != 0) begin
                    s = exp_sram.pop_front();
                    chk("sram_addr", sramAddress, s.addr);
                    chk("sram_data", sramWriteData, s.data);
                end
                sram_mem[sramAddress[9:2]] = sramWriteData;
                sram_wr_cnt++;
            end
            if (dramReq && dramAck) begin
                chk("dram_op_expected", 32'(exp_dram.size() != 0), 1);
                if (exp_dram.size() != 0) begin
                    d = exp_dram.pop_front();
                    chk("dram_dir", 32'(dramWrite), 32'(d.wr));
                    chk("dram_addr", dramAddress, d.addr);
                    if (d.wr) chk("dram_wdata", dramWriteData, d.data);
                end
                if (dramWrite) dram_mem[dramAddress[9:2]] = dramWriteData;
            end
            if (dmaDone) begin
                chk("done_expected", 32'(exp_done > 0), 1);
                chk("stall_low_at_done", 32'(stall), 0);
                if (exp_done > 0) exp_done--;
            end
            prev_wait = dramReq && !dramAck && !reset;
            prev_wr   = dramWrite;
            prev_addr = dramAddress;
            prev_data = dramWriteData;
        end
    end

    // Reference model: expected traffic per command, then drive it (caller is at posedge+1).
    task automatic issue(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                         input int w);
        logic [31:0] sa, da;
        for (int i = 0; i < w; i++) begin
            sa = {src[31:2], 2'b00} + 32'(4 * i);
            da = {dst[31:2], 2'b00} + 32'(4 * i);
            case (cmd)
                2'b01: begin
                    exp_dram.push_back('{wr: 1'b0, addr: sa, data: 32'h0});
                    exp_sram.push_back('{addr: da, data: dram_mem[sa[9:2]]});
                end
                2'b10: exp_dram.push_back('{wr: 1'b1, addr: da, data: sram_mem[sa[9:2]]});
                2'b11: exp_sram.push_back('{addr: da, data: src});
                default: ;
            endcase
        end
        if (cmd != 2'b00 && w != 0) exp_done++;
        dmaCmd = cmd;
        dmaSrcAddress = src;
        dmaDstAddress = dst;
        dmaWidth = 10'(w);
    endtask

    // Holds the command until dmaDone (the stalled instruction), then moves on to a no-op.
    task automatic run(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                       input int w, input int lat, input int exp_stall, input int exp_done_cyc);
        int stall_cycles, k;
        logic got;
        dram_lat = lat;
        @(posedge clk); #1;
        issue(cmd, src, dst, w);
        stall_cycles = 0;
        got = 1'b0;
        k = 0;
        while (k < 2000 && !got) begin
            @(negedge clk);
            k++;
            if (dmaDone) got = 1'b1;
            else stall_cycles += int'(stall);
        end
        chk("done_seen", 32'(got), 1);
        if (exp_stall >= 0) chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
        if (exp_done_cyc >= 0) chk("done_cycle", 32'(k), 32'(exp_done_cyc));
        @(posedge clk); #1;
        dmaCmd = 2'b00;
        @(negedge clk);
        chk("no_retrigger_stall", 32'(stall), 0);
        chk("no_retrigger_req", 32'(dramReq), 0);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        dmaCmd = 2'b00;
        dmaSrcAddress = '0;
        dmaDstAddress = '0;
        dmaWidth = '0;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = $urandom;
            dram_mem[i] = $urandom;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_done", 32'(dmaDone), 0);
        chk("rst_dramReq", 32'(dramReq), 0);
        chk("rst_dramWrite", 32'(dramWrite), 0);
        chk("rst_sramWE", 32'(sramWriteEnable), 0);
        chk("rst_dramAddress", dramAddress, 0);
        chk("rst_dramWriteData", dramWriteData, 0);
        chk("rst_sramAddress", sramAddress, 0);
        chk("rst_sramWriteData", sramWriteData, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // d2s, 1 wait cycle per request: 2 cycles/word, last SRAM write one cycle after last ack
        for (int i = 0; i < 4; i++) dram_mem[4 + i] = 32'(i + 1);
        run(2'b01, 32'd16, 32'd24, 4, 1, 10, 11);
        for (int i = 0; i < 4; i++) chk("d2s_sram_word", sram_mem[6 + i], 32'(i + 1));

        // s2d, ack latency 3
        for (int i = 0; i < 8; i++) sram_mem[i] = 32'h100 + 32'(i);
        run(2'b10, 32'd0, 32'h200, 8, 3, -1, -1);
        for (int i = 0; i < 8; i++) chk("s2d_dram_word", dram_mem[128 + i], 32'h100 + 32'(i));

        // fill: stall N+1 cycles, done in cycle N+2
        run(2'b11, 32'hDEADBEEF, 32'h40, 3, 1, 4, 5);
        for (int i = 0; i < 3; i++) chk("fill_sram_word", sram_mem[16 + i], 32'hDEADBEEF);

        // width 0 is ignored
        @(posedge clk); #1;
        issue(2'b01, 32'h10, 32'h20, 0);
        repeat (3) begin
            @(negedge clk);
            chk("w0_stall", 32'(stall), 0);
            chk("w0_dramReq", 32'(dramReq), 0);
        end
        @(posedge clk); #1;
        dmaCmd = 2'b00;

        // reset in the middle of a 6-word d2s
        dram_lat = 1;
        @(posedge clk); #1;
        base = sram_wr_cnt;
        issue(2'b01, 32'h80, 32'h300, 6);
        for (int k = 0; k < 200 && sram_wr_cnt < base + 2; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_reset_progress", 32'(sram_wr_cnt >= base + 2), 1);
        reset = 1'b1;
        dmaCmd = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_sram.delete();
        exp_dram.delete();
        exp_done = 0;
        @(negedge clk);
        chk("post_reset_stall", 32'(stall), 0);
        chk("post_reset_dramReq", 32'(dramReq), 0);
        run(2'b11, 32'hA5A5_0F0F, 32'h100, 5, 1, 6, 7);

        // address wrap: 0xFFFFFFFC then 0x00000000
        run(2'b01, 32'hFFFF_FFFC, 32'h3C0, 2, 1, 6, 7);

        // randomized commands
        for (int t = 0; t < 12; t++) begin
            logic [1:0]  cmd;
            logic [31:0] src, dst;
            int w, lat;
            cmd = 2'($urandom_range(1, 3));
            w   = int'($urandom_range(1, 8));
            lat = int'($urandom_range(0, 3));
            src = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            dst = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (cmd == 2'b11) begin
                src = $urandom;
                run(cmd, src, dst, w, lat, w + 1, w + 2);
            end else begin
                run(cmd, src, dst, w, lat, -1, -1);
            end
        end

        repeat (3) @(negedge clk);
        chk("sram_queue_drained", 32'(exp_sram.size()), 0);
        chk("dram_queue_drained", 32'(exp_dram.size()), 0);
        chk("done_count_drained", 32'(exp_done), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule

// File: doc/dma_engine.md
# dma_engine

Parametrised DMA controller that serves the `dmaCmd` port of `mips_pipeline`. It moves word blocks between external DRAM and the local `sram` scratchpad in either direction, and adds an SRAM fill mode. A FIFO decouples the source and destination sides. The block drives the pipeline `stall` input for the whole transfer, so the issuing instruction is held until the copy completes.

## Interface
- `ADDR_W`, 32: byte-address width on the command, DRAM and SRAM sides.
- `WIDTH_W`, 10: width of `dmaWidth`, the transfer length in 32-bit words.
- `FIFO_DEPTH`, 4: FIFO depth in words; must be a power of two, ≥2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `dmaCmd` in 2: 00 none, 01 d2s (DRAM→SRAM), 10 s2d (SRAM→DRAM), 11 fill (write `dmaSrcAddress` value into SRAM).
- `dmaSrcAddress` in ADDR_W: source byte address (fill: the 32-bit fill pattern).
- `dmaDstAddress` in ADDR_W: destination byte address.
- `dmaWidth` in WIDTH_W: number of words to transfer.
- `stall` out 1: freezes the pipeline.
- `dmaDone` out 1: one-cycle pulse when a transfer completes.
- `dramReq` out 1: DRAM request, held until ack.
- `dramWrite` out 1: 1 = write, 0 = read, valid with `dramReq`.
- `dramAddress` out ADDR_W, `dramWriteData` out 32: request address/data.
- `dramAck` in 1: one-cycle acknowledge; `dramReadData` in 32 valid in that cycle.
- `sramAddress` out ADDR_W, `sramWriteEnable` out 1, `sramWriteData` out 32: SRAM port.
- `sramReadData` in 32: combinational read of `sramAddress`.

## Operation
- States: IDLE, XFER, FILL, DONE.
- IDLE:
  - Command accepted when `dmaCmd`≠00 and `dmaWidth`≠0.
  - Latches src, dst, width and mode; clears counters and FIFO.
  - Goes to XFER (01/10) or FILL (11).
  - `dmaCmd`≠00 with `dmaWidth`=0: ignored, no stall.
- Addresses are word-aligned byte addresses; bits [1:0] are ignored. Each word advances the address by 4 and wraps modulo 2^ADDR_W.
- XFER has two concurrent sides and a FIFO:
  - Producer: issues source reads while `fetched`<width and FIFO count<FIFO_DEPTH (registered count; a same-cycle pop does not unblock a push).
  - Consumer: writes the destination while the FIFO is non-empty.
- d2s:
  - Producer raises `dramReq`, `dramWrite`=0. The word is pushed on the edge ending the `dramAck` cycle.
  - Consumer drives `sramWriteEnable`=1 with the FIFO head, one word per cycle.
- s2d:
  - Producer reads SRAM combinationally and pushes one word per cycle.
  - Consumer raises `dramReq`, `dramWrite`=1 with the head. The word is popped on the `dramAck` edge.
- DRAM handshake:
  - Address, data and `dramWrite` stay stable while `dramReq`=1 and no ack.
  - At most one request outstanding.
  - `dramReq` may stay high into the next request in the cycle after an ack.
- Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- XFER→DONE when `written`==width.
- FILL: one SRAM write per cycle of the pattern to dst, dst+4, …; → DONE after the width-th write.
- DONE: `dmaDone`=1, `stall`=0, `dmaCmd` ignored; → IDLE next cycle. This prevents the still-held instruction from re-triggering.
- Reset in any state:
  - Next edge: IDLE, counters and FIFO cleared, `dramReq` dropped.
  - Already-written words are not undone.

## Timing
- Reset values: `stall`=0, `dmaDone`=0, `dramReq`=0, `dramWrite`=0, `sramWriteEnable`=0; `dramAddress`, `dramWriteData`, `sramAddress`, `sramWriteData`=0.
- `stall` is combinational: 1 when in IDLE with an acceptable command (same cycle the command appears), and in XFER and FILL; 0 in DONE.
- Fill of N words: `stall` high N+1 cycles (accept + N FILL); `dmaDone` in cycle N+2.
- d2s with DRAM acking in the 2nd cycle of each request: 2 cycles/word; SRAM writes lag DRAM acks by one cycle.
- s2d with the same DRAM model: 2 cycles/word, DRAM-limited. The FIFO fills within FIFO_DEPTH cycles, after which the producer stalls.
- `dmaDone` is high for exactly one cycle per accepted command.

## Test plan
- d2s: DRAM[16..28]=1,2,3,4; cmd 01, src 16, dst 24, width 4, 1-cycle-latency DRAM → SRAM words 6..9 = 1..4, `stall` high throughout, one `dmaDone`, then the pipeline resumes and the next instruction is not re-triggered.
- s2d: SRAM[0..7]=0x100..0x107; cmd 10, width 8, FIFO_DEPTH 4, DRAM ack latency 3 → DRAM holds the same 8 words in order; FIFO never exceeds 4; `dramAddress` and `dramWriteData` stable while waiting.
- Fill: cmd 11, src 0xDEADBEEF, dst 0x40, width 3 → SRAM words 16..18 = DEADBEEF; `stall` high exactly 4 cycles.
- Width 0 with cmd 01 → no `stall`, no `dramReq`, no `dmaDone`.
- Reset asserted mid-d2s after 2 of 6 words → next cycle IDLE, `stall`=0, `dramReq`=0; a new fill command then runs correctly.
- Address wrap: ADDR_W=16, d2s src 0xFFFC, width 2 → DRAM reads 0xFFFC then 0x0000.
